// File: rtl/instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_prefetch_buffer
//   Fetch stage sitting right after the PC register. Issues in-order requests
//   to instruction memory, tags each returned word with its PC and queues it in
//   a small FIFO towards decode. A redirect flushes the queue and throws away
//   every response still in flight for the old path.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   fetch_en_i            permits new memory requests
//   redirect_i/_pc_i      flush and restart fetch at redirect_pc_i (word aligned)
//   imem_req_o/_addr_o    request valid / address
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/_rdata_i in-order response, one or more cycles after grant
//   instr_valid_o/_ready_i decode handshake on the FIFO head
//   instr_o, instr_pc_o   head instruction word and its PC
//
// state | meaning
// IDLE  | after reset, no requests until fetch_en_i
// RUN   | issue requests while credit allows, collect responses into FIFO
// DRAIN | wait for responses of the flushed path, discard their data
// -----------------------------------------------------------------------------
module instr_prefetch_buffer #(
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          DepthLog2 = 2,
   parameter logic [AddrWidth-1:0] ResetPc   = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 fetch_en_i,
   input  logic                 redirect_i,
   input  logic [AddrWidth-1:0] redirect_pc_i,
   output logic                 imem_req_o,
   output logic [AddrWidth-1:0] imem_addr_o,
   input  logic                 imem_gnt_i,
   input  logic                 imem_rvalid_i,
   input  logic [DataWidth-1:0] imem_rdata_i,
   output logic                 instr_valid_o,
   input  logic                 instr_ready_i,
   output logic [DataWidth-1:0] instr_o,
   output logic [AddrWidth-1:0] instr_pc_o
);

   localparam int unsigned    Depth = 2 ** DepthLog2;
   localparam int unsigned    CntW  = DepthLog2 + 1;
   localparam logic [CntW:0]  DepthCnt = (CntW + 1)'(Depth);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_e;

   state_e                 state_q, state_d;
   logic [AddrWidth-1:0]   fetch_pc_q, fetch_pc_d;
   logic [AddrWidth-1:0]   rsp_pc_q, rsp_pc_d;
   logic [CntW-1:0]        count_q, count_d;
   logic [CntW-1:0]        outstanding_q, outstanding_d;
   logic [CntW-1:0]        stale_q, stale_d;
   logic [DepthLog2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DepthLog2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DataWidth-1:0]   data_mem_q [Depth];
   logic [DataWidth-1:0]   data_mem_d [Depth];
   logic [AddrWidth-1:0]   pc_mem_q [Depth];
   logic [AddrWidth-1:0]   pc_mem_d [Depth];

   logic                   credit_ok;
   logic                   req;
   logic                   gnt_fire;
   logic                   rsp_fire;
   logic                   push;
   logic                   pop;
   logic [AddrWidth-1:0]   redirect_pc_aligned;

   // Credit looks only at registered occupancy: a pop this cycle frees its
   // slot from the next cycle, so granted words always have a FIFO entry.
   assign credit_ok = ((CntW + 1)'(count_q) + (CntW + 1)'(outstanding_q)) < DepthCnt;
   assign req       = (state_q == ST_RUN) & fetch_en_i & credit_ok & ~redirect_i;
   assign gnt_fire  = req & imem_gnt_i;
   // A response with nothing outstanding is a protocol error and is dropped.
   assign rsp_fire  = imem_rvalid_i & (outstanding_q != '0);
   assign push      = rsp_fire & (state_q == ST_RUN) & ~redirect_i;
   assign pop       = instr_valid_o & instr_ready_i;

   assign redirect_pc_aligned = {redirect_pc_i[AddrWidth-1:2], 2'b00};

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      stale_d       = stale_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      data_mem_d    = data_mem_q;
      pc_mem_d      = pc_mem_q;

      case ({gnt_fire, rsp_fire})
         2'b10:   outstanding_d = outstanding_q + CntW'(1);
         2'b01:   outstanding_d = outstanding_q - CntW'(1);
         default: outstanding_d = outstanding_q;
      endcase

      if (redirect_i) begin
         fetch_pc_d = redirect_pc_aligned;
         rsp_pc_d   = redirect_pc_aligned;
         if (state_q != ST_IDLE) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            // req is forced low, so outstanding_d already excludes any grant
            // and already accounts for a response dropped in this cycle.
            stale_d  = outstanding_d;
            state_d  = (outstanding_d != '0) ? ST_DRAIN : ST_RUN;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fetch_en_i) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (gnt_fire) fetch_pc_d = fetch_pc_q + AddrWidth'(4);
               if (push) begin
                  data_mem_d[wr_ptr_q] = imem_rdata_i;
                  pc_mem_d[wr_ptr_q]   = rsp_pc_q;
                  wr_ptr_d             = wr_ptr_q + DepthLog2'(1);
                  rsp_pc_d             = rsp_pc_q + AddrWidth'(4);
               end
            end
            ST_DRAIN: begin
               if (rsp_fire) begin
                  stale_d = stale_q - CntW'(1);
                  if (stale_q == CntW'(1)) state_d = ST_RUN;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (pop) rd_ptr_d = rd_ptr_q + DepthLog2'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      // Storage needs no reset: the head is gated by count_q.
      data_mem_q <= data_mem_d;
      pc_mem_q   <= pc_mem_d;
      if (rst_i) begin
         state_q       <= ST_IDLE;
         fetch_pc_q    <= ResetPc;
         rsp_pc_q      <= ResetPc;
         count_q       <= '0;
         outstanding_q <= '0;
         stale_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   assign imem_req_o    = req;
   assign imem_addr_o   = fetch_pc_q;
   assign instr_valid_o = (count_q != '0);
   assign instr_o       = instr_valid_o ? data_mem_q[rd_ptr_q] : '0;
   assign instr_pc_o    = instr_valid_o ? pc_mem_q[rd_ptr_q] : '0;

   a_rvalid_has_req: assert property (@(posedge clk_i) disable iff (rst_i)
      !(imem_rvalid_i && (outstanding_q == '0)));

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && !pop && (count_q == CntW'(Depth))));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        fetch_en_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;

   always #5 clk_i = ~clk_i;

   instr_prefetch_buffer dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .fetch_en_i    (fetch_en_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // per-cycle stimulus controls, applied shortly after each rising edge
   bit          ctl_rst = 1'b1;
   bit          ctl_fe = 1'b0;
   bit          ctl_redir = 1'b0;
   logic [31:0] ctl_redir_pc = '0;
   int          gnt_pct = 100;
   int          rdy_pct = 100;
   int          lat = 1;

   // memory: granted addresses waiting to be returned, in order
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   // reference: fetch stream as seen from the outside
   bit          m_run = 1'b0;
   int          m_live = 0;
   int          m_stale = 0;
   logic [31:0] m_fifo[$];
   logic [31:0] m_fetch = '0;
   bit          prev_wait = 1'b0;
   logic [31:0] prev_addr = '0;

   int          n_gnt = 0;
   int          n_pop = 0;
   int          first_valid_cyc = -1;
   logic [31:0] first_pop_pc = '0;
   logic [31:0] last_pop_pc = '0;

   task automatic step();
      bit          rv;
      bit          exp_req;
      logic [31:0] rv_addr;
      @(posedge clk_i);
      cyc++;
      #1;
      rst_i         = ctl_rst;
      fetch_en_i    = ctl_fe;
      redirect_i    = ctl_redir;
      redirect_pc_i = ctl_redir_pc;
      imem_gnt_i    = ($urandom_range(99) < gnt_pct);
      instr_ready_i = ($urandom_range(99) < rdy_pct);
      rv      = 1'b0;
      rv_addr = '0;
      if (!ctl_rst && mq_due.size() > 0 && mq_due[0] <= cyc) begin
         rv      = 1'b1;
         rv_addr = mq_addr.pop_front();
         void'(mq_due.pop_front());
      end
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? (rv_addr ^ KEY) : $urandom;
      #1;
      if (ctl_rst) begin
         mq_addr.delete();
         mq_due.delete();
         m_fifo.delete();
         m_run = 1'b0;
         m_live = 0;
         m_stale = 0;
         m_fetch = '0;
         prev_wait = 1'b0;
         first_valid_cyc = -1;
         ctl_redir = 1'b0;
         return;
      end

      exp_req = m_run && (m_stale == 0) && ctl_fe && !ctl_redir && (m_live < 4);
      n_cmp++;
      if (imem_req_o !== exp_req) begin
         n_err++;
         $display("FAIL req cyc=%0d: got %b expected %b", cyc, imem_req_o, exp_req);
      end
      if (prev_wait) begin
         n_cmp++;
         if (imem_addr_o !== prev_addr) begin
            n_err++;
            $display("FAIL addr_hold cyc=%0d: got %h expected %h", cyc, imem_addr_o, prev_addr);
         end
      end
      if (imem_req_o && imem_gnt_i) begin
         n_cmp++;
         if (imem_addr_o !== m_fetch) begin
            n_err++;
            $display("FAIL grant_addr cyc=%0d: got %h expected %h", cyc, imem_addr_o, m_fetch);
         end
         mq_addr.push_back(imem_addr_o);
         mq_due.push_back(cyc + lat);
         m_fetch = m_fetch + 32'd4;
         m_live++;
         n_gnt++;
      end
      prev_wait = imem_req_o && !imem_gnt_i;
      prev_addr = imem_addr_o;

      n_cmp++;
      if (instr_valid_o !== (m_fifo.size() != 0)) begin
         n_err++;
         $display("FAIL valid cyc=%0d: got %b expected %b", cyc, instr_valid_o, m_fifo.size() != 0);
      end
      if (instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (instr_valid_o && m_fifo.size() != 0) begin
         n_cmp++;
         if (instr_pc_o !== m_fifo[0] || instr_o !== (m_fifo[0] ^ KEY)) begin
            n_err++;
            $display("FAIL head cyc=%0d: got pc=%h data=%h expected pc=%h data=%h",
                     cyc, instr_pc_o, instr_o, m_fifo[0], m_fifo[0] ^ KEY);
         end
         if (instr_ready_i) begin
            if (n_pop == 0) first_pop_pc = instr_pc_o;
            last_pop_pc = instr_pc_o;
            n_pop++;
            void'(m_fifo.pop_front());
            m_live--;
         end
      end

      if (ctl_redir) begin
         m_fetch = {ctl_redir_pc[31:2], 2'b00};
         if (m_run) begin
            m_fifo.delete();
            m_live = 0;
            m_stale = mq_addr.size();
         end
      end else begin
         if (rv) begin
            if (m_stale > 0) m_stale--;
            else if (m_run) m_fifo.push_back(rv_addr);
         end
         if (!m_run && ctl_fe) m_run = 1'b1;
      end
      ctl_redir = 1'b0;
   endtask

   task automatic do_reset();
      ctl_rst = 1'b1;
      ctl_fe  = 1'b0;
      step();
      ctl_rst = 1'b0;
   endtask

   task automatic test_reset();
      gnt_pct = 100; rdy_pct = 100; lat = 1;
      do_reset();
      step();
      n_cmp++;
      if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
      n_cmp++;
      if (imem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", imem_addr_o); end
      n_cmp++;
      if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o); end
      n_cmp++;
      if (instr_o !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", instr_o); end
      n_cmp++;
      if (instr_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", instr_pc_o); end
   endtask

   task automatic test_stream();
      int c0;
      gnt_pct = 100; rdy_pct = 100; lat = 1;
      do_reset();
      n_pop = 0;
      ctl_fe = 1'b1;
      step();
      c0 = cyc;
      repeat (20) step();
      n_cmp++;
      if (first_valid_cyc - c0 != 3) begin
         n_err++;
         $display("FAIL stream_latency: got %0d expected 3", first_valid_cyc - c0);
      end
      n_cmp++;
      if (n_pop != 18) begin n_err++; $display("FAIL stream_pops: got %0d expected 18", n_pop); end
      n_cmp++;
      if (last_pop_pc !== 32'h44) begin n_err++; $display("FAIL stream_last_pc: got %h expected 44", last_pop_pc); end
   endtask

   task automatic test_backpressure();
      gnt_pct = 100; rdy_pct = 0; lat = 1;
      do_reset();
      n_gnt = 0;
      ctl_fe = 1'b1;
      repeat (12) step();
      n_cmp++;
      if (n_gnt != 4) begin n_err++; $display("FAIL bp_grants: got %0d expected 4", n_gnt); end
      n_cmp++;
      if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL bp_req_low: got %b expected 0", imem_req_o); end
      n_cmp++;
      if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin
         n_err++;
         $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=0", instr_valid_o, instr_pc_o);
      end
      n_pop = 0;
      rdy_pct = 100;
      repeat (5) step();
      n_cmp++;
      if (n_pop != 5 || last_pop_pc !== 32'h10) begin
         n_err++;
         $display("FAIL bp_resume: got pops=%0d last=%h expected pops=5 last=10", n_pop, last_pop_pc);
      end
   endtask

   task automatic test_redirect_drain();
      gnt_pct = 100; rdy_pct = 100; lat = 2;
      do_reset();
      ctl_fe = 1'b1;
      repeat (7) step();
      ctl_redir = 1'b1;
      ctl_redir_pc = 32'h0000_0102;
      step();
      n_pop = 0;
      step();
      n_cmp++;
      if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL drain_quiet: got valid=%b req=%b expected 0 0", instr_valid_o, imem_req_o);
      end
      repeat (8) step();
      n_cmp++;
      if (n_pop == 0 || first_pop_pc !== 32'h100) begin
         n_err++;
         $display("FAIL drain_first_pc: got pops=%0d pc=%h expected pc=100", n_pop, first_pop_pc);
      end
   endtask

   task automatic test_redirect_rvalid();
      gnt_pct = 0; rdy_pct = 100; lat = 1;
      do_reset();
      ctl_fe = 1'b1;
      step();
      step();
      gnt_pct = 100;
      step();
      gnt_pct = 0;
      ctl_redir = 1'b1;
      ctl_redir_pc = 32'h0000_0040;
      step();
      step();
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40 || instr_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL redir_rvalid: got req=%b addr=%h valid=%b expected 1 40 0",
                  imem_req_o, imem_addr_o, instr_valid_o);
      end
   endtask

   task automatic test_random();
      gnt_pct = 50; rdy_pct = 60; lat = 2;
      do_reset();
      n_pop = 0;
      for (int i = 0; i < 500; i++) begin
         ctl_fe = ($urandom_range(7) != 0);
         if (i == 250) begin
            ctl_redir = 1'b1;
            ctl_redir_pc = 32'hFFFF_FFF6;
         end else if ($urandom_range(39) == 0) begin
            ctl_redir = 1'b1;
            ctl_redir_pc = $urandom;
         end
         step();
      end
      n_cmp++;
      if (n_pop < 50) begin n_err++; $display("FAIL random_progress: got %0d pops expected >=50", n_pop); end
   endtask

   task automatic test_reset_mid();
      gnt_pct = 100; rdy_pct = 0; lat = 3;
      do_reset();
      ctl_fe = 1'b1;
      repeat (4) step();
      ctl_rst = 1'b1;
      step();
      ctl_rst = 1'b0;
      ctl_fe = 1'b0;
      rdy_pct = 100;
      step();
      n_cmp++;
      if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || instr_valid_o !== 1'b0 ||
          instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
         n_err++;
         $display("FAIL midreset_outputs: got req=%b addr=%h valid=%b instr=%h pc=%h expected all 0",
                  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o);
      end
      repeat (3) step();
      ctl_fe = 1'b1;
      step();
      step();
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
         n_err++;
         $display("FAIL midreset_restart: got req=%b addr=%h expected 1 0", imem_req_o, imem_addr_o);
      end
      repeat (6) step();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drain();
      test_redirect_rvalid();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Fetch stage directly downstream of the PC register.
- Owns the sequential fetch address and issues in-order requests to instruction memory.
- Buffers returned instruction words, each tagged with its PC, in a small FIFO feeding decode over a valid/ready handshake.
- A redirect (branch/jump) from the PC path flushes the buffer and discards all stale in-flight responses.

Parameters:
AddrWidth, 32, fetch address / PC width
DataWidth, 32, instruction word width
DepthLog2, 2, log2 of FIFO depth (default 4 entries); also bounds outstanding requests
ResetPc, 32'h0000_0000, fetch address loaded at reset

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
fetch_en_i  in  1  permits new memory requests
redirect_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  AddrWidth  new fetch address
imem_req_o  out  1  memory request valid
imem_addr_o  out  AddrWidth  request address
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid; responses return in order, 1+ cycles after grant
imem_rdata_i  in  DataWidth  response instruction word
instr_valid_o  out  1  FIFO head valid
instr_ready_i  in  1  decode accepts head
instr_o  out  DataWidth  head instruction
instr_pc_o  out  AddrWidth  PC of head instruction

Behaviour:
- Reset: state IDLE; fetch_pc = rsp_pc = ResetPc; count = outstanding = stale = 0.
- Reset outputs: imem_req_o=0, imem_addr_o=ResetPc, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- Reset mid-operation: every in-flight response is forgotten; any rvalid in the cycle after reset is ignored.
- States: IDLE, RUN, DRAIN.
- IDLE: no requests. fetch_en_i=1 -> RUN next cycle.
- RUN: imem_req_o = fetch_en_i & (count + outstanding < 2**DepthLog2); imem_addr_o = fetch_pc.
- Grant: imem_req_o & imem_gnt_i -> fetch_pc += 4, outstanding += 1.
- Credit uses registered count/outstanding only; a pop frees a slot from the next cycle. The FIFO therefore never overflows.
- Response: imem_rvalid_i in RUN -> push {imem_rdata_i, rsp_pc}; rsp_pc += 4; outstanding -= 1.
- Grant and response in the same cycle: outstanding unchanged.
- rvalid with outstanding=0 is a protocol violation: ignored, flagged by an assertion.
- Output latency: a word returned in cycle N appears on instr_valid_o/instr_o in cycle N+1 (registered FIFO, no bypass).
- instr_valid_o = (count != 0). Pop on instr_valid_o & instr_ready_i. Push and pop in the same cycle are both honoured.
- Head outputs hold stable while valid & !ready. instr_o/instr_pc_o are don't-care when invalid.
- Redirect (highest priority, any state):
  - FIFO cleared; fetch_pc = rsp_pc = {redirect_pc_i[AddrWidth-1:2], 2'b00}.
  - imem_req_o forced 0 in the redirect cycle.
  - stale = outstanding (+1 if a grant would otherwise occur is impossible since req is forced low); a response arriving in the redirect cycle is discarded and counted against stale.
  - Next state: DRAIN if remaining stale > 0, else RUN. From IDLE, redirect only updates fetch_pc/rsp_pc and stays IDLE.
- DRAIN: no requests; each rvalid drops its data and decrements stale/outstanding.
  - stale hits 0 -> RUN next cycle.
  - Redirect in DRAIN reloads PCs; stale = current outstanding.
- fetch_en_i=0 in RUN: no new requests; responses are still collected and drained to decode.
- Wrap-around: fetch_pc/rsp_pc wrap modulo 2**AddrWidth.

Test Plan:
- Reset, fetch_en_i=1, memory always grants with 1-cycle rvalid, rdata=addr^32'hA5A5_A5A5, ready=1 -> instr_pc_o sequence 0,4,8,... with matching rdata; first instr_valid_o 3 cycles after fetch_en_i rises.
- instr_ready_i=0, memory always grants -> exactly 4 requests issued (addr 0..C), imem_req_o low after; head holds instr_pc_o=0; raising ready drains 0,4,8,C and fetching resumes.
- Grant 2-cycle latency, redirect_i to 32'h0000_0102 with 2 requests outstanding -> both responses dropped, FIFO empty; next request addr 32'h0000_0100; first delivered instr_pc_o=32'h100.
- Redirect in the same cycle as an rvalid, with outstanding=1 -> that data discarded; direct RUN next cycle; no DRAIN.
- imem_gnt_i randomly low 50% -> addr stays stable while req & !gnt; no duplicate or skipped PCs at decode.
- Assert rst_i mid-stream with 3 outstanding -> all outputs at reset values next cycle; fetch restarts at ResetPc after fetch_en_i.
